// File: rtl/seq_detect_pkg.sv
// Shared constants for the configurable serial pattern detector.
// The default pattern is the legacy fixed 1011 sequence.
package seq_detect_pkg;

  localparam int         DEF_MAX_LEN = 8;
  localparam logic [7:0] DEF_PATTERN = 8'b0000_1011;
  localparam int         DEF_LEN     = 4;
  localparam bit         DEF_OVERLAP = 1'b1;

  // Length fields must hold the value MAX_LEN itself, not just MAX_LEN-1.
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating event counter with a synchronous clear.
// The clear input takes priority over a simultaneous increment.
module seq_match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_cfg.sv
// Runtime-configurable serial bit-pattern detector.
// It provides a registered match pulse and a saturating match counter.
module seq_detect_cfg
  import seq_detect_pkg::*;
#(
  parameter int                 MAX_LEN     = DEF_MAX_LEN,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_PATTERN),
  parameter int                 RST_LEN     = DEF_LEN,
  parameter bit                 RST_OVERLAP = DEF_OVERLAP,
  parameter int                 LEN_W       = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inp_bit,
  input  logic               inp_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               seq_seen,
  output logic [CNT_W-1:0]   match_count,
  output logic [LEN_W-1:0]   cur_len
);

  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   len;
  logic               ovl;

  logic [MAX_LEN-1:0] hist_n;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_n;
  logic [LEN_W-1:0]   len_clamped;
  logic               hit;
  logic               accept;

  // Candidate history and fill level if this cycle's bit is accepted.
  // Only the newest len bits of the history take part in the compare.
  always_comb begin
    hist_n = {hist[MAX_LEN-2:0], inp_bit};
    fill_n = (int'(fill) >= MAX_LEN) ? LEN_W'(MAX_LEN) : fill + LEN_W'(1);
    mask   = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
    hit         = (len != '0) && (fill_n >= len) && ((hist_n & mask) == (pat & mask));
    accept      = inp_valid && !cfg_load;
    len_clamped = (int'(cfg_len) > MAX_LEN) ? LEN_W'(MAX_LEN) : cfg_len;
  end

  // A config load drops any bit presented in the same cycle and restarts the fill.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist     <= '0;
      fill     <= '0;
      pat      <= RST_PATTERN;
      len      <= LEN_W'(RST_LEN);
      ovl      <= RST_OVERLAP;
      seq_seen <= 1'b0;
    end else if (cfg_load) begin
      pat      <= cfg_pattern;
      len      <= len_clamped;
      ovl      <= cfg_overlap;
      fill     <= '0;
      seq_seen <= 1'b0;
    end else if (inp_valid) begin
      hist     <= hist_n;
      fill     <= (hit && !ovl) ? '0 : fill_n;
      seq_seen <= hit;
    end else begin
      seq_seen <= 1'b0;
    end
  end

  seq_match_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr),
    .inc  (accept && hit),
    .count(match_count)
  );

  assign cur_len = len;

endmodule

// File: tb/tb_seq_detect_cfg.sv
// Directed self-checking bench for seq_detect_cfg.
// A second instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_seq_detect_cfg;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               inp_bit = 1'b0;
  logic               inp_valid = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               cnt_clr = 1'b0;

  logic               seq_seen;
  logic [7:0]         match_count;
  logic [LEN_W-1:0]   cur_len;
  logic               seq_seen_s;
  logic [1:0]         match_count_s;
  logic [LEN_W-1:0]   cur_len_s;

  int total_count = 0;
  int bad_count   = 0;

  always #5 clk = ~clk;

  seq_detect_cfg #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .inp_bit(inp_bit), .inp_valid(inp_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr), .seq_seen(seq_seen),
    .match_count(match_count), .cur_len(cur_len)
  );

  seq_detect_cfg #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .inp_bit(inp_bit), .inp_valid(inp_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr), .seq_seen(seq_seen_s),
    .match_count(match_count_s), .cur_len(cur_len_s)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_count++;
    if (observed !== expected) begin
      bad_count++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of serial input, then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic b, input logic v);
    inp_bit   = b;
    inp_valid = v;
    @(posedge clk);
    #1;
    inp_valid = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic loadCfg(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic o);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    cfg_load    = 1'b1;
    applyStimulus(1'b0, 1'b0);
    cfg_load    = 1'b0;
  endtask

  task automatic clearCount();
    cnt_clr = 1'b1;
    applyStimulus(1'b0, 1'b0);
    cnt_clr = 1'b0;
  endtask

  // Stream n bits (MSB of the used field first) and check seq_seen after each.
  task automatic sendStream(input string tag, input logic [15:0] bits, input int n, input logic [15:0] exp_seen);
    for (int i = n - 1; i >= 0; i--) begin
      applyStimulus(bits[i], 1'b1);
      checkOutput($sformatf("%s_bit%0d", tag, n - i), {31'b0, seq_seen}, {31'b0, exp_seen[i]});
    end
  endtask

  initial begin
    $display("[TB] starting seq_detect_cfg bench");

    doReset();
    doReset();
    checkOutput("rst_seen", {31'b0, seq_seen}, 32'd0);
    checkOutput("rst_count", {24'b0, match_count}, 32'd0);
    checkOutput("rst_len", {28'b0, cur_len}, 32'd4);

    sendStream("dflt_ovl", 16'b1011011, 7, 16'b0001001);
    checkOutput("dflt_ovl_count", {24'b0, match_count}, 32'd2);

    clearCount();
    checkOutput("clr_count", {24'b0, match_count}, 32'd0);
    loadCfg(8'b0000_1011, 4'd4, 1'b0);
    checkOutput("nonovl_len", {28'b0, cur_len}, 32'd4);
    sendStream("nonovl", 16'b1011011, 7, 16'b0001000);
    checkOutput("nonovl_count", {24'b0, match_count}, 32'd1);

    clearCount();
    loadCfg(8'b0000_0111, 4'd3, 1'b1);
    sendStream("ones_ovl", 16'b11111, 5, 16'b00111);
    checkOutput("ones_ovl_count", {24'b0, match_count}, 32'd3);

    clearCount();
    loadCfg(8'b0000_0111, 4'd3, 1'b0);
    sendStream("ones_nonovl", 16'b111111, 6, 16'b001001);
    checkOutput("ones_nonovl_count", {24'b0, match_count}, 32'd2);

    // Idle cycles between accepted bits must hold the history.
    doReset();
    begin
      logic [3:0] gap_bits;
      gap_bits = 4'b1011;
      for (int i = 3; i >= 0; i--) begin
        applyStimulus(gap_bits[i], 1'b1);
        checkOutput($sformatf("gap_bit%0d", 4 - i), {31'b0, seq_seen}, {31'b0, (i == 0)});
        for (int k = 0; k < 2 && i > 0; k++) begin
          applyStimulus(1'b0, 1'b0);
          checkOutput($sformatf("gap_idle%0d_%0d", 4 - i, k), {31'b0, seq_seen}, 32'd0);
        end
      end
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("gap_after_idle", {31'b0, seq_seen}, 32'd0);
    checkOutput("gap_count", {24'b0, match_count}, 32'd1);

    doReset();
    sendStream("pre_rst", 16'b101, 3, 16'b000);
    doReset();
    sendStream("post_rst", 16'b1, 1, 16'b0);
    checkOutput("post_rst_count", {24'b0, match_count}, 32'd0);

    // A bit presented with cfg_load is dropped and the fill restarts.
    doReset();
    sendStream("pre_load", 16'b101, 3, 16'b000);
    cfg_pattern = 8'b0000_1011;
    cfg_len     = 4'd4;
    cfg_overlap = 1'b1;
    cfg_load    = 1'b1;
    applyStimulus(1'b1, 1'b1);
    cfg_load    = 1'b0;
    checkOutput("load_bit_seen", {31'b0, seq_seen}, 32'd0);
    sendStream("post_load", 16'b011, 3, 16'b000);
    sendStream("post_load2", 16'b1011, 4, 16'b0001);

    loadCfg(8'b1010_1010, 4'd11, 1'b1);
    checkOutput("clamp_len", {28'b0, cur_len}, 32'd8);
    sendStream("full8", 16'b10101010, 8, 16'b00000001);

    loadCfg(8'b0000_0000, 4'd0, 1'b1);
    checkOutput("len0_len", {28'b0, cur_len}, 32'd0);
    sendStream("len0", 16'b0000, 4, 16'b0000);

    loadCfg(8'b0000_0001, 4'd1, 1'b1);
    sendStream("len1", 16'b101, 3, 16'b101);

    doReset();
    sendStream("sat", 16'b1011011011011011, 16, 16'b0001001001001001);
    checkOutput("sat_count_wide", {24'b0, match_count}, 32'd5);
    checkOutput("sat_count_narrow", {30'b0, match_count_s}, 32'd3);

    // Clear wins over a hit in the same cycle.
    doReset();
    sendStream("clr_hit_a", 16'b1011, 4, 16'b0001);
    checkOutput("clr_hit_pre", {24'b0, match_count}, 32'd1);
    sendStream("clr_hit_b", 16'b01, 2, 16'b00);
    cnt_clr = 1'b1;
    applyStimulus(1'b1, 1'b1);
    cnt_clr = 1'b0;
    checkOutput("clr_hit_seen", {31'b0, seq_seen}, 32'd1);
    checkOutput("clr_hit_count", {24'b0, match_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total_count, bad_count);
    $finish;
  end

endmodule
